// File: rtl/remap_ppu_pipe_pkg.sv
// Shared constants for the PPU requantization pipe: lane geometry, latency, datapath widths.
package remap_ppu_pipe_pkg;

    localparam int unsigned S           = 8;
    localparam int unsigned R           = 16;
    localparam int unsigned N           = S * R;
    localparam int unsigned LANE_W      = 8;
    localparam int unsigned PPU_LATENCY = 5;

    localparam int unsigned XZ_W   = 9;
    localparam int unsigned YZ_W   = 8;
    localparam int unsigned M1_W   = 26;
    localparam int unsigned N1_W   = 6;
    localparam int unsigned D_W    = 10;
    localparam int unsigned P_W    = 36;
    localparam int unsigned Y_W    = P_W + 1;
    localparam int unsigned SH_MAX = 35;

endpackage

// File: rtl/remap_ppu_pipe_lane.sv
// One lane of the 5-stage requantizer: Y = sat_u8(((X - Xz) * m1 [+ rnd]) >>> min(n1,35) + Yz).
// Rounding add (half toward +inf) is enabled by defining PPU_ROUND_EN.
module ppu_lane
    import remap_ppu_pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANE_W-1:0]      i_x,
    input  logic signed [XZ_W-1:0] i_neg_xz,
    input  logic [M1_W-1:0]        i_m1_s1,
    input  logic [N1_W-1:0]        i_n1_s3,
    input  logic [YZ_W-1:0]        i_yz_s4,
    output logic [LANE_W-1:0]      o_y
);

    logic signed [D_W-1:0]  r_d;
    logic signed [P_W-1:0]  r_p_a;
    logic signed [P_W-1:0]  r_p;
    logic signed [P_W-1:0]  r_q;
    logic [LANE_W-1:0]      r_y;

    logic signed [D_W-1:0]  w_d;
    logic signed [M1_W:0]   w_m1s;
    logic signed [P_W-1:0]  w_prod;
    logic [N1_W-1:0]        w_sh;
    logic signed [P_W-1:0]  w_rnd;
    logic signed [P_W-1:0]  w_q;
    logic signed [Y_W-1:0]  w_y;
    logic [LANE_W-1:0]      w_sat;

    // Per-stage arithmetic; params arrive already aligned to the stage that uses them.
    always_comb begin
        w_d    = $signed({2'b00, i_x}) + D_W'(i_neg_xz);
        w_m1s  = $signed({1'b0, i_m1_s1});
        w_prod = P_W'(r_d) * P_W'(w_m1s);
        w_sh   = (i_n1_s3 > N1_W'(SH_MAX)) ? N1_W'(SH_MAX) : i_n1_s3;
        w_rnd  = '0;
`ifdef PPU_ROUND_EN
        if (w_sh != '0) begin
            w_rnd = P_W'(1) << (w_sh - N1_W'(1));
        end
`endif
        w_q    = (r_p + w_rnd) >>> w_sh;
        w_y    = Y_W'(r_q) + Y_W'($signed({1'b0, i_yz_s4}));
        if (w_y < 0) begin
            w_sat = '0;
        end else if (w_y > Y_W'(255)) begin
            w_sat = '1;
        end else begin
            w_sat = w_y[LANE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d   <= '0;
            r_p_a <= '0;
            r_p   <= '0;
            r_q   <= '0;
            r_y   <= '0;
        end else begin
            r_d   <= w_d;
            r_p_a <= w_prod;
            r_p   <= r_p_a;
            r_q   <= w_q;
            r_y   <= w_sat;
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/remap_ppu_pipe.sv
// PPU requantization responder: N-lane fixed-latency pipe with vld/last and per-beat params carried alongside.
// Optional rounding controlled by macro PPU_ROUND_EN (see ppu_lane).
module remap_ppu_pipe
    import remap_ppu_pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*LANE_W-1:0]    ppus_Xs,
    input  logic                   ppus_Xs_vld,
    input  logic                   ppus_Xs_last,
    input  logic signed [XZ_W-1:0] ppus_neg_Xz,
    input  logic [YZ_W-1:0]        ppus_Yz,
    input  logic [M1_W-1:0]        ppus_m1,
    input  logic [N1_W-1:0]        ppus_n1,
    output logic [N*LANE_W-1:0]    ppus_outs,
    output logic                   ppus_out_vld,
    output logic                   ppus_out_last
);

    logic [PPU_LATENCY-1:0] r_vld;
    logic [PPU_LATENCY-1:0] r_last;
    logic [M1_W-1:0]        r_m1_s1;
    logic [N1_W-1:0]        r_n1_s1, r_n1_s2, r_n1_s3;
    logic [YZ_W-1:0]        r_yz_s1, r_yz_s2, r_yz_s3, r_yz_s4;

    // Control and parameter pipeline; each param is dropped once its stage has consumed it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r_last  <= '0;
            r_m1_s1 <= '0;
            r_n1_s1 <= '0;
            r_n1_s2 <= '0;
            r_n1_s3 <= '0;
            r_yz_s1 <= '0;
            r_yz_s2 <= '0;
            r_yz_s3 <= '0;
            r_yz_s4 <= '0;
        end else begin
            r_vld   <= {r_vld[PPU_LATENCY-2:0], ppus_Xs_vld};
            r_last  <= {r_last[PPU_LATENCY-2:0], ppus_Xs_vld & ppus_Xs_last};
            r_m1_s1 <= ppus_m1;
            r_n1_s1 <= ppus_n1;
            r_n1_s2 <= r_n1_s1;
            r_n1_s3 <= r_n1_s2;
            r_yz_s1 <= ppus_Yz;
            r_yz_s2 <= r_yz_s1;
            r_yz_s3 <= r_yz_s2;
            r_yz_s4 <= r_yz_s3;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        ppu_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_x      (ppus_Xs[g*LANE_W +: LANE_W]),
            .i_neg_xz (ppus_neg_Xz),
            .i_m1_s1  (r_m1_s1),
            .i_n1_s3  (r_n1_s3),
            .i_yz_s4  (r_yz_s4),
            .o_y      (ppus_outs[g*LANE_W +: LANE_W])
        );
    end

    assign ppus_out_vld  = r_vld[PPU_LATENCY-1];
    assign ppus_out_last = r_last[PPU_LATENCY-1];

endmodule

// File: tb/tb_remap_ppu_pipe.sv
// Randomized + directed bench for remap_ppu_pipe against a cycle-indexed behavioural model.
module tb_remap_ppu_pipe;
    import remap_ppu_pipe_pkg::*;

    localparam int unsigned VW   = N * LANE_W;
    localparam int          MAXC = 1024;
    localparam int          LAT  = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [VW-1:0]          ppus_Xs;
    logic                   ppus_Xs_vld;
    logic                   ppus_Xs_last;
    logic signed [XZ_W-1:0] ppus_neg_Xz;
    logic [YZ_W-1:0]        ppus_Yz;
    logic [M1_W-1:0]        ppus_m1;
    logic [N1_W-1:0]        ppus_n1;
    logic [VW-1:0]          ppus_outs;
    logic                   ppus_out_vld;
    logic                   ppus_out_last;

    always #5 clk = ~clk;

    remap_ppu_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .ppus_Xs       (ppus_Xs),
        .ppus_Xs_vld   (ppus_Xs_vld),
        .ppus_Xs_last  (ppus_Xs_last),
        .ppus_neg_Xz   (ppus_neg_Xz),
        .ppus_Yz       (ppus_Yz),
        .ppus_m1       (ppus_m1),
        .ppus_n1       (ppus_n1),
        .ppus_outs     (ppus_outs),
        .ppus_out_vld  (ppus_out_vld),
        .ppus_out_last (ppus_out_last)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Golden requantizer written directly from the arithmetic definition.
    function automatic int ref_y(input int x, input int nxz, input int m1, input int n1, input int yz);
        longint p, q, y;
        int     sh;
        p  = longint'(x + nxz) * longint'(m1);
        sh = (n1 > 35) ? 35 : n1;
`ifdef PPU_ROUND_EN
        if (sh > 0) p = p + (longint'(1) << (sh - 1));
`endif
        q = p >>> sh;
        y = q + longint'(yz);
        if (y < 0)   return 0;
        if (y > 255) return 255;
        return int'(y);
    endfunction

    function automatic logic [VW-1:0] fill(input int b);
        logic [VW-1:0] v;
        for (int i = 0; i < int'(N); i++) v[i*8 +: 8] = 8'(b);
        return v;
    endfunction

    // History per sampling edge: what went in, and what must come out LAT-1 edges later.
    bit            rst_h  [MAXC];
    bit            vld_h  [MAXC];
    bit            last_h [MAXC];
    logic [VW-1:0] exp_h  [MAXC];
    logic [VW-1:0] cur_exp;
    int            cyc = -1;

    always @(posedge clk) begin
        cyc++;
        if (cyc < MAXC) begin
            rst_h[cyc]  = rst;
            vld_h[cyc]  = ppus_Xs_vld && !rst;
            last_h[cyc] = ppus_Xs_last && ppus_Xs_vld && !rst;
            exp_h[cyc]  = cur_exp;
        end
    end

    always @(negedge clk) begin
        if (cyc >= 0 && cyc < MAXC) begin
            int  e;
            bit  flushed, ev, el;
            e = cyc;
            flushed = 1'b0;
            for (int k = e - (LAT - 1); k <= e; k++) begin
                if (k < 0 || rst_h[k]) flushed = 1'b1;
            end
            ev = !flushed && vld_h[e-(LAT-1)];
            el = !flushed && last_h[e-(LAT-1)];
            chk($sformatf("out_vld@%0d", e), longint'(ppus_out_vld), longint'(ev));
            chk($sformatf("out_last@%0d", e), longint'(ppus_out_last), longint'(el));
            if (rst_h[e]) begin
                for (int i = 0; i < int'(N); i++)
                    chk($sformatf("outs_rst@%0d lane%0d", e, i),
                        longint'(ppus_outs[i*8 +: 8]), 0);
            end else if (ev) begin
                for (int i = 0; i < int'(N); i++)
                    chk($sformatf("outs@%0d lane%0d", e, i),
                        longint'(ppus_outs[i*8 +: 8]), longint'(exp_h[e-(LAT-1)][i*8 +: 8]));
            end
        end
    end

    // Present one beat for one cycle; exp_y >= 0 gives a fixed expected value for every lane.
    task automatic drive(input logic [VW-1:0] xs, input int nxz, input int yz, input int m1,
                         input int n1, input bit vld, input bit last, input int exp_y);
        ppus_Xs      = xs;
        ppus_neg_Xz  = XZ_W'(nxz);
        ppus_Yz      = YZ_W'(yz);
        ppus_m1      = M1_W'(m1);
        ppus_n1      = N1_W'(n1);
        ppus_Xs_vld  = vld;
        ppus_Xs_last = last;
        for (int i = 0; i < int'(N); i++)
            cur_exp[i*8 +: 8] = (exp_y >= 0) ? 8'(exp_y)
                              : 8'(ref_y(int'(xs[i*8 +: 8]), nxz, m1, n1, yz));
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input bit vld, input bit last);
        logic [VW-1:0] xs;
        int nxz, yz, m1, n1;
        for (int i = 0; i < int'(N); i++) xs[i*8 +: 8] = 8'($urandom);
        nxz = -int'($urandom_range(255, 0));
        yz  = int'($urandom_range(255, 0));
        m1  = int'($urandom_range(32'h03ff_ffff, 0));
        n1  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(34, 18)) : int'($urandom_range(63, 0));
        drive(xs, nxz, yz, m1, n1, vld, last, -1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_rand(1'b0, 1'b0);
    endtask

    int r_pos, r_neg;

    initial begin
        rst          = 1'b1;
        ppus_Xs      = '0;
        ppus_Xs_vld  = 1'b0;
        ppus_Xs_last = 1'b0;
        ppus_neg_Xz  = '0;
        ppus_Yz      = '0;
        ppus_m1      = '0;
        ppus_n1      = '0;
        cur_exp      = '0;
`ifdef PPU_ROUND_EN
        r_pos = 102;
        r_neg = 99;
`else
        r_pos = 101;
        r_neg = 98;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed corner cases.
        drive(fill(200), -128, 10, 1 << 25, 26, 1'b1, 1'b1, 46);
        idle(2);
        drive(fill(255), 0, 0, (1 << 26) - 1, 20, 1'b1, 1'b0, 255);
        drive(fill(0), -255, 0, 1 << 20, 20, 1'b1, 1'b1, 0);
        drive(fill(3), 0, 100, 1, 1, 1'b1, 1'b1, r_pos);
        drive(fill(0), -3, 100, 1, 1, 1'b1, 1'b1, r_neg);
        drive(fill(255), 0, 7, 1, 63, 1'b1, 1'b0, 7);
        drive(fill(0), -5, 10, 1, 0, 1'b1, 1'b1, 5);
        drive(fill(9), 0, 0, 1, 0, 1'b0, 1'b1, -1);
        idle(6);

        // 64-beat burst, params changing every beat.
        for (int b = 0; b < 64; b++) drive_rand(1'b1, b == 63);
        idle(6);

        // Reset in the middle of a 10-beat burst.
        for (int b = 0; b < 10; b++) begin
            rst = (b == 2 || b == 3);
            drive_rand(1'b1, b == 9);
        end
        rst = 1'b0;
        idle(8);

        if (cyc >= MAXC) begin
            n_fail++;
            $display("FAIL cycle_budget: observed %0d expected below %0d", cyc, MAXC);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
